// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake, operands and result of the bit-serial adder
interface serial_adder_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic Cin;
  logic busy;
  logic done;
  logic [WIDTH-1:0] Sum;
  logic Cout;
  modport master (output start, A, B, Cin, input busy, done, Sum, Cout);
  modport slave (input start, A, B, Cin, output busy, done, Sum, Cout);
endinterface

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder, one full-adder cell and a carry flip-flop
module serial_adder #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  serial_adder_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] sh_a, sh_b, sum;
  logic carry, cout, busy, done;
  logic [CW-1:0] cnt;
  logic s, c_next;
  assign s = sh_a[0] ^ sh_b[0] ^ carry;
  assign c_next = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.Sum = sum;
  assign bus.Cout = cout;
  // IDLE and DONE both accept a start, which gives back-to-back issue without an idle cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
      sh_a <= '0;
      sh_b <= '0;
      carry <= 1'b0;
      cnt <= '0;
    end else if (state == SHIFT) begin
      carry <= c_next;
      sum <= {s, sum[WIDTH-1:1]};
      sh_a <= {1'b0, sh_a[WIDTH-1:1]};
      sh_b <= {1'b0, sh_b[WIDTH-1:1]};
      cnt <= cnt + 1'b1;
      if (cnt == CW'(WIDTH - 1)) begin
        state <= DONE;
        busy <= 1'b0;
        done <= 1'b1;
        cout <= c_next;
      end
    end else begin
      done <= 1'b0;
      if (bus.start) begin
        state <= SHIFT;
        busy <= 1'b1;
        sh_a <= bus.A;
        sh_b <= bus.B;
        carry <= bus.Cin;
        cnt <= '0;
        sum <= '0;
      end else begin
        state <= IDLE;
        busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of the bit-serial adder handshake and result
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int n;
  logic [7:0] a, b;
  logic ci;
  logic [8:0] exp_sum;
  serial_adder_if #(.WIDTH(8)) bus ();
  serial_adder #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // leaves the bench at the falling edge just after the accepting edge E0
  task automatic start_op(input logic [7:0] ia, input logic [7:0] ib, input logic icin);
    @(negedge clk);
    bus.A = ia;
    bus.B = ib;
    bus.Cin = icin;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.Cin = 1'b0;
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sum", bus.Sum, 0);
    chk("rst_cout", bus.Cout, 0);
    @(negedge clk);
    rst = 1'b0;
    // 1: 100+27, busy for exactly eight sampled cycles
    start_op(8'd100, 8'd27, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("t1_busy", bus.busy, 1);
      chk("t1_nodone", bus.done, 0);
      @(negedge clk);
    end
    chk("t1_done", bus.done, 1);
    chk("t1_busy_low", bus.busy, 0);
    chk("t1_sum", bus.Sum, 127);
    chk("t1_cout", bus.Cout, 0);
    @(negedge clk);
    chk("t1_pulse", bus.done, 0);
    chk("t1_held", bus.Sum, 127);
    // 2: wrap cases
    start_op(8'hFF, 8'h01, 1'b0);
    wait_done(n);
    chk("t2a_lat", n, 8);
    chk("t2a_sum", bus.Sum, 0);
    chk("t2a_cout", bus.Cout, 1);
    start_op(8'hAA, 8'h55, 1'b1);
    wait_done(n);
    chk("t2b_lat", n, 8);
    chk("t2b_sum", bus.Sum, 0);
    chk("t2b_cout", bus.Cout, 1);
    // 3: start while busy is ignored
    start_op(8'd3, 8'd4, 1'b0);
    @(negedge clk);
    @(negedge clk);
    bus.A = 8'd9;
    bus.B = 8'd9;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n);
    chk("t3_lat", n, 5);
    chk("t3_sum", bus.Sum, 7);
    chk("t3_cout", bus.Cout, 0);
    @(negedge clk);
    chk("t3_one_pulse", bus.done, 0);
    chk("t3_idle", bus.busy, 0);
    // 4: back-to-back start during the done cycle
    start_op(8'd5, 8'd6, 1'b0);
    wait_done(n);
    chk("t4a_sum", bus.Sum, 11);
    bus.A = 8'd10;
    bus.B = 8'd20;
    bus.Cin = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("t4_nogap_busy", bus.busy, 1);
    chk("t4_nogap_done", bus.done, 0);
    wait_done(n);
    chk("t4_lat", n, 8);
    chk("t4_sum", bus.Sum, 31);
    chk("t4_cout", bus.Cout, 0);
    // 5: asynchronous reset at E4 aborts the add
    start_op(8'd200, 8'd100, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t5_busy", bus.busy, 0);
    chk("t5_done", bus.done, 0);
    chk("t5_sum", bus.Sum, 0);
    chk("t5_cout", bus.Cout, 0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) n++;
    end
    chk("t5_no_done", n, 0);
    start_op(8'd1, 8'd1, 1'b0);
    wait_done(n);
    chk("t5_fresh_sum", bus.Sum, 2);
    chk("t5_fresh_cout", bus.Cout, 0);
    // 6: random operands; operand inputs scrambled after acceptance
    for (int k = 0; k < 1000; k++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      ci = 1'($urandom);
      exp_sum = 9'(a) + 9'(b) + 9'(ci);
      start_op(a, b, ci);
      bus.A = 8'($urandom);
      bus.B = 8'($urandom);
      bus.Cin = 1'($urandom);
      wait_done(n);
      chk("t6_lat", n, 8);
      chk("t6_result", {bus.Cout, bus.Sum}, exp_sum);
      @(negedge clk);
      chk("t6_one_pulse", bus.done, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
